// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the synchronous instruction SRAM
// and presents the fetched instruction plus its PC to the decode stage.
// A one-entry hold buffer keeps the SRAM word alive across decode stalls.
// Branch/jump redirects follow MIPS delay-slot semantics.
// Exception/ERET flushes take priority over stalls.
// Misaligned fetch PCs are flagged as AdEL when they reach decode.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'hBFC00000,
    parameter logic [31:0] NOP_INSTR = 32'h00000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        is_branchD,
    input  logic        exc_valid,
    input  logic [31:0] exc_pc,
    output logic        inst_sram_en,
    output logic [31:0] inst_sram_addr,
    input  logic [31:0] inst_sram_rdata,
    output logic [31:0] instrD,
    output logic [31:0] pcD,
    output logic [31:0] pc_plus8D,
    output logic        validD,
    output logic        delayslotD,
    output logic        adelD
);

    logic [31:0] pcF;
    logic        hold_valid;
    logic [31:0] hold_instr;

    // PC, decode-slot and hold-buffer registers: exception beats stall, stall beats redirect, redirect beats sequential fetch
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pcF        <= RESET_PC;
            pcD        <= 32'h0;
            validD     <= 1'b0;
            delayslotD <= 1'b0;
            hold_valid <= 1'b0;
            hold_instr <= NOP_INSTR;
        end else if (exc_valid) begin
            pcF        <= exc_pc;
            validD     <= 1'b0;
            delayslotD <= 1'b0;
            hold_valid <= 1'b0;
        end else if (stall) begin
            if (!hold_valid) begin
                hold_instr <= inst_sram_rdata;
                hold_valid <= 1'b1;
            end
        end else if (redirect_valid) begin
            pcD        <= pcF;
            pcF        <= redirect_pc;
            validD     <= 1'b1;
            delayslotD <= is_branchD;
            hold_valid <= 1'b0;
        end else begin
            pcD        <= pcF;
            pcF        <= pcF + 32'd4;
            validD     <= 1'b1;
            delayslotD <= is_branchD;
            hold_valid <= 1'b0;
        end
    end

    // The SRAM is re-read every cycle; a misaligned PC must not reach memory
    assign inst_sram_addr = pcF;
    assign inst_sram_en   = ~rst & (pcF[1:0] == 2'b00);

    // Address error is only meaningful for an occupied decode slot
    assign adelD     = validD & (pcD[1:0] != 2'b00);
    assign pc_plus8D = pcD + 32'd8;

    // Decode instruction select: bubble or fault gives NOP, otherwise the held word wins over live SRAM data
    always_comb begin
        instrD = inst_sram_rdata;
        if (!validD || adelD) begin
            instrD = NOP_INSTR;
        end else if (hold_valid) begin
            instrD = hold_instr;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: a table of per-cycle stimulus with the
// decode-side outputs expected after the following clock edge, fed through a
// scoreboard queue, plus a hand-written asynchronous-reset sequence.
module tb_fetch_stage;

    localparam logic [31:0] T = 32'hBFC00000;

    typedef struct {
        logic        stall;
        logic        redir;
        logic [31:0] rpc;
        logic        br;
        logic        exc;
        logic [31:0] epc;
        logic [31:0] pcD;
        logic        validD;
        logic        ds;
        logic        adel;
        logic [31:0] instr;
        logic [31:0] addr;
        logic        en;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        is_branchD;
    logic        exc_valid;
    logic [31:0] exc_pc;
    logic        inst_sram_en;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_rdata = 32'h0;
    logic [31:0] instrD;
    logic [31:0] pcD;
    logic [31:0] pc_plus8D;
    logic        validD;
    logic        delayslotD;
    logic        adelD;

    int vectorsApplied = 0;
    int miscompares    = 0;

    vec_t vecs[$];
    vec_t expQ[$];

    fetch_stage dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .is_branchD      (is_branchD),
        .exc_valid       (exc_valid),
        .exc_pc          (exc_pc),
        .inst_sram_en    (inst_sram_en),
        .inst_sram_addr  (inst_sram_addr),
        .inst_sram_rdata (inst_sram_rdata),
        .instrD          (instrD),
        .pcD             (pcD),
        .pc_plus8D       (pc_plus8D),
        .validD          (validD),
        .delayslotD      (delayslotD),
        .adelD           (adelD)
    );

    always #5 clk = ~clk;

    // Memory contents: a scrambled function of the address, never equal to the NOP word for these addresses
    function automatic logic [31:0] memWord(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'hC3A50F1E;
    endfunction

    // Synchronous one-cycle-latency instruction SRAM model
    always @(posedge clk) begin
        if (inst_sram_en) inst_sram_rdata <= memWord(inst_sram_addr);
    end

    function automatic vec_t mk(input logic s, input logic r, input logic [31:0] rp, input logic b,
                                input logic e, input logic [31:0] ep, input logic [31:0] p,
                                input logic v, input logic d, input logic ad,
                                input logic [31:0] ins, input logic [31:0] ad32, input logic en);
        vec_t x;
        x.stall = s; x.redir = r; x.rpc = rp; x.br = b; x.exc = e; x.epc = ep;
        x.pcD = p; x.validD = v; x.ds = d; x.adel = ad; x.instr = ins; x.addr = ad32; x.en = en;
        return x;
    endfunction

    task automatic checkField(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s (step %0d): got %h, expected %h", name, idx, act, exp);
        end
    endtask

    task automatic checkOutput(input vec_t e, input int idx);
        checkField("pcD",        idx, pcD,                  e.pcD);
        checkField("validD",     idx, {31'b0, validD},      {31'b0, e.validD});
        checkField("delayslotD", idx, {31'b0, delayslotD},  {31'b0, e.ds});
        checkField("adelD",      idx, {31'b0, adelD},       {31'b0, e.adel});
        checkField("instrD",     idx, instrD,               e.instr);
        checkField("sram_addr",  idx, inst_sram_addr,       e.addr);
        checkField("sram_en",    idx, {31'b0, inst_sram_en}, {31'b0, e.en});
        checkField("pc_plus8D",  idx, pc_plus8D,            e.pcD + 32'd8);
    endtask

    task automatic applyStimulus(input vec_t v);
        stall          = v.stall;
        redirect_valid = v.redir;
        redirect_pc    = v.rpc;
        is_branchD     = v.br;
        exc_valid      = v.exc;
        exc_pc         = v.epc;
    endtask

    initial begin
        vec_t e;
        vec_t idle;
        idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // stimulus for this cycle -> outputs expected after the next rising edge
        vecs.push_back(mk(0,0,0,0,0,0,  T,       1,0,0, memWord(T),       T+32'h4,   1));
        vecs.push_back(mk(0,0,0,0,0,0,  T+32'h4, 1,0,0, memWord(T+32'h4), T+32'h8,   1));
        vecs.push_back(mk(1,0,0,0,0,0,  T+32'h4, 1,0,0, memWord(T+32'h4), T+32'h8,   1));
        vecs.push_back(mk(1,0,0,0,0,0,  T+32'h4, 1,0,0, memWord(T+32'h4), T+32'h8,   1));
        vecs.push_back(mk(1,0,0,0,0,0,  T+32'h4, 1,0,0, memWord(T+32'h4), T+32'h8,   1));
        vecs.push_back(mk(0,0,0,0,0,0,  T+32'h8, 1,0,0, memWord(T+32'h8), T+32'hC,   1));
        vecs.push_back(mk(0,0,0,0,0,0,  T+32'hC, 1,0,0, memWord(T+32'hC), T+32'h10,  1));
        vecs.push_back(mk(0,0,0,0,0,0,  T+32'h10,1,0,0, memWord(T+32'h10),T+32'h14,  1));
        vecs.push_back(mk(0,1,T+32'h100,1,0,0, T+32'h14, 1,1,0, memWord(T+32'h14), T+32'h100, 1));
        vecs.push_back(mk(0,0,0,0,0,0,  T+32'h100,1,0,0, memWord(T+32'h100),T+32'h104, 1));
        vecs.push_back(mk(0,0,0,0,0,0,  T+32'h104,1,0,0, memWord(T+32'h104),T+32'h108, 1));
        vecs.push_back(mk(1,1,T+32'h200,1,0,0, T+32'h104, 1,0,0, memWord(T+32'h104), T+32'h108, 1));
        vecs.push_back(mk(1,1,T+32'h200,1,0,0, T+32'h104, 1,0,0, memWord(T+32'h104), T+32'h108, 1));
        vecs.push_back(mk(0,1,T+32'h200,1,0,0, T+32'h108, 1,1,0, memWord(T+32'h108), T+32'h200, 1));
        vecs.push_back(mk(0,0,0,0,0,0,  T+32'h200,1,0,0, memWord(T+32'h200),T+32'h204, 1));
        vecs.push_back(mk(1,0,0,0,0,0,  T+32'h200,1,0,0, memWord(T+32'h200),T+32'h204, 1));
        vecs.push_back(mk(1,0,0,0,1,T+32'h380, T+32'h200, 0,0,0, 32'h0, T+32'h380, 1));
        vecs.push_back(mk(0,0,0,0,0,0,  T+32'h380,1,0,0, memWord(T+32'h380),T+32'h384, 1));
        vecs.push_back(mk(0,0,0,0,1,T+32'h382, T+32'h380, 0,0,0, 32'h0, T+32'h382, 0));
        vecs.push_back(mk(0,0,0,0,0,0,  T+32'h382,1,0,1, 32'h0, T+32'h386, 0));
        vecs.push_back(mk(0,0,0,0,1,T+32'h380, T+32'h382, 0,0,0, 32'h0, T+32'h380, 1));
        vecs.push_back(mk(0,1,32'hFFFFFFFC,0,0,0, T+32'h380, 1,0,0, memWord(T+32'h380), 32'hFFFFFFFC, 1));
        vecs.push_back(mk(0,0,0,0,0,0,  32'hFFFFFFFC,1,0,0, memWord(32'hFFFFFFFC), 32'h0, 1));
        vecs.push_back(mk(0,0,0,0,0,0,  32'h0,   1,0,0, memWord(32'h0),   32'h4,     1));

        // Reset state: enable is forced low while reset is asserted
        rst = 1'b1;
        applyStimulus(idle);
        repeat (2) @(posedge clk);
        #1;
        checkOutput(mk(0,0,0,0,0,0, 32'h0, 0,0,0, 32'h0, T, 0), -1);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput(mk(0,0,0,0,0,0, 32'h0, 0,0,0, 32'h0, T, 1), -2);

        // Table-driven run through the scoreboard
        foreach (vecs[i]) begin
            applyStimulus(vecs[i]);
            expQ.push_back(vecs[i]);
            @(posedge clk);
            #1;
            e = expQ.pop_front();
            checkOutput(e, i);
            vectorsApplied++;
        end

        // Asynchronous reset in the middle of a stalled redirect discards everything
        applyStimulus(mk(1,1,T+32'h500,1,0,0, 0,0,0,0, 0,0,0));
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        checkOutput(mk(0,0,0,0,0,0, 32'h0, 0,0,0, 32'h0, T, 0), 100);
        vectorsApplied++;
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(idle);
        #1;
        checkOutput(mk(0,0,0,0,0,0, 32'h0, 0,0,0, 32'h0, T, 1), 101);
        @(posedge clk);
        #1;
        checkOutput(mk(0,0,0,0,0,0, T, 1,0,0, memWord(T), T+32'h4, 1), 102);
        vectorsApplied += 2;

        $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
        $finish;
    end

endmodule
